// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline stage with a two-entry skid buffer.
// The main slot drives the outputs; the skid slot absorbs the word already in
// flight when downstream stalls, so in_ready comes only from registered state.
// Flush discards both slots and parks the output on FLUSH_PC.
// Optional feature macro: PIPE_BUBBLE_PC_EN. When defined, a non-flush bubble
// carries the upstream in_pc/in_bd so a later stage can report a precise EPC.
module pipe_stage_reg #(
   parameter int          PAYLOAD_W = 96,
   parameter logic [31:0] FLUSH_PC  = 32'h0000_3000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_pc,
   input  logic                 in_bd,
   input  logic [4:0]           in_exc,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_pc,
   output logic                 out_bd,
   output logic [4:0]           out_exc,
   output logic [PAYLOAD_W-1:0] out_payload
);

   // main slot (drives the outputs)
   logic                 main_valid_r, main_valid_s;
   logic [31:0]          main_pc_r, main_pc_s;
   logic                 main_bd_r, main_bd_s;
   logic [4:0]           main_exc_r, main_exc_s;
   logic [PAYLOAD_W-1:0] main_payload_r, main_payload_s;

   // skid slot (holds the word accepted while main was stalled)
   logic                 skid_valid_r, skid_valid_s;
   logic [31:0]          skid_pc_r, skid_pc_s;
   logic                 skid_bd_r, skid_bd_s;
   logic [4:0]           skid_exc_r, skid_exc_s;
   logic [PAYLOAD_W-1:0] skid_payload_r, skid_payload_s;

   logic accept_s;
   logic main_free_s;

   assign in_ready    = !skid_valid_r;
   assign accept_s    = in_valid & !skid_valid_r;
   assign main_free_s = !main_valid_r | out_ready;

   assign out_valid   = main_valid_r;
   assign out_pc      = main_pc_r;
   assign out_bd      = main_bd_r;
   assign out_exc     = main_exc_r;
   assign out_payload = main_payload_r;

   // next-state selection for both slots; flush overrides every other event
   always_comb begin
      main_valid_s   = main_valid_r;
      main_pc_s      = main_pc_r;
      main_bd_s      = main_bd_r;
      main_exc_s     = main_exc_r;
      main_payload_s = main_payload_r;
      skid_valid_s   = skid_valid_r;
      skid_pc_s      = skid_pc_r;
      skid_bd_s      = skid_bd_r;
      skid_exc_s     = skid_exc_r;
      skid_payload_s = skid_payload_r;

      if (flush) begin
         main_valid_s   = 1'b0;
         main_pc_s      = FLUSH_PC;
         main_bd_s      = 1'b0;
         main_exc_s     = 5'd0;
         main_payload_s = '0;
         skid_valid_s   = 1'b0;
      end else if (main_free_s) begin
         if (skid_valid_r) begin
            // oldest word moves forward; no accept is possible while skid is full
            main_valid_s   = 1'b1;
            main_pc_s      = skid_pc_r;
            main_bd_s      = skid_bd_r;
            main_exc_s     = skid_exc_r;
            main_payload_s = skid_payload_r;
            skid_valid_s   = 1'b0;
         end else if (accept_s) begin
            main_valid_s   = 1'b1;
            main_pc_s      = in_pc;
            main_bd_s      = in_bd;
            main_exc_s     = in_exc;
            main_payload_s = in_payload;
         end else begin
            // bubble: nothing to load
            main_valid_s   = 1'b0;
            main_exc_s     = 5'd0;
            main_payload_s = '0;
`ifdef PIPE_BUBBLE_PC_EN
            main_pc_s      = in_pc;
            main_bd_s      = in_bd;
`else
            main_pc_s      = FLUSH_PC;
            main_bd_s      = 1'b0;
`endif
         end
      end else begin
         // main stalled: an accepted word parks in skid
         if (accept_s) begin
            skid_valid_s   = 1'b1;
            skid_pc_s      = in_pc;
            skid_bd_s      = in_bd;
            skid_exc_s     = in_exc;
            skid_payload_s = in_payload;
         end else begin
            skid_valid_s   = skid_valid_r;
         end
      end
   end

   // slot registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_valid_r   <= 1'b0;
         main_pc_r      <= FLUSH_PC;
         main_bd_r      <= 1'b0;
         main_exc_r     <= 5'd0;
         main_payload_r <= '0;
         skid_valid_r   <= 1'b0;
         skid_pc_r      <= FLUSH_PC;
         skid_bd_r      <= 1'b0;
         skid_exc_r     <= 5'd0;
         skid_payload_r <= '0;
      end else begin
         main_valid_r   <= main_valid_s;
         main_pc_r      <= main_pc_s;
         main_bd_r      <= main_bd_s;
         main_exc_r     <= main_exc_s;
         main_payload_r <= main_payload_s;
         skid_valid_r   <= skid_valid_s;
         skid_pc_r      <= skid_pc_s;
         skid_bd_r      <= skid_bd_s;
         skid_exc_r     <= skid_exc_s;
         skid_payload_r <= skid_payload_s;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_pipe_stage_reg;

   localparam int          PW   = 16;
   localparam logic [31:0] FPC  = 32'h0000_3000;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_pc;
   logic          in_bd;
   logic [4:0]    in_exc;
   logic [PW-1:0] in_payload;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_pc;
   logic          out_bd;
   logic [4:0]    out_exc;
   logic [PW-1:0] out_payload;

   int checks;
   int failures;

   pipe_stage_reg #(.PAYLOAD_W(PW), .FLUSH_PC(FPC)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_bd       (in_bd),
      .in_exc      (in_exc),
      .in_payload  (in_payload),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_bd      (out_bd),
      .out_exc     (out_exc),
      .out_payload (out_payload)
   );

   // free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic bd,
                        input logic [4:0] exc, input logic [PW-1:0] pl);
      in_valid   = v;
      in_pc      = pc;
      in_bd      = bd;
      in_exc     = exc;
      in_payload = pl;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},   64'(out_valid),   64'd0);
      check({tag, "_pc"},      64'(out_pc),      64'(FPC));
      check({tag, "_bd"},      64'(out_bd),      64'd0);
      check({tag, "_exc"},     64'(out_exc),     64'd0);
      check({tag, "_payload"}, 64'(out_payload), 64'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // reset held with a valid word offered upstream
      reset     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_1234, 1'b1, 5'd7, 16'hAAAA);
      #12;
      check_reset_outputs("rst");
      check("rst_in_ready", 64'(in_ready), 64'd1);
      drive(1'b0, 32'h0, 1'b0, 5'd0, 16'h0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("rel_in_ready", 64'(in_ready), 64'd1);
      check("rel_valid",    64'(out_valid), 64'd0);

      // streaming: payload 1..8, one word per cycle, 1 cycle latency
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'h0000_0100 + 32'(4 * i), 1'b0, 5'(i), 16'(i));
         tick();
         check("stream_valid",   64'(out_valid),   64'd1);
         check("stream_payload", 64'(out_payload), 64'(i));
         check("stream_pc",      64'(out_pc),      64'(32'h0000_0100 + 32'(4 * i)));
         check("stream_exc",     64'(out_exc),     64'(i));
         check("stream_ready",   64'(in_ready),    64'd1);
      end

      // bubble while main drains, upstream stalled at 0x3010 in a delay slot
      drive(1'b0, 32'h0000_3010, 1'b1, 5'd9, 16'hBEEF);
      tick();
      check("bub_valid",   64'(out_valid),   64'd0);
      check("bub_exc",     64'(out_exc),     64'd0);
      check("bub_payload", 64'(out_payload), 64'd0);
`ifdef PIPE_BUBBLE_PC_EN
      check("bub_pc", 64'(out_pc), 64'h3010);
      check("bub_bd", 64'(out_bd), 64'd1);
`else
      check("bub_pc", 64'(out_pc), 64'h3000);
      check("bub_bd", 64'(out_bd), 64'd0);
`endif

      // backpressure: out_ready low 4 cycles while feeding A, B, C
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0200, 1'b0, 5'd3, 16'h00A1);
      tick();
      check("bp1_payload", 64'(out_payload), 64'h00A1);
      check("bp1_exc",     64'(out_exc),     64'd3);
      check("bp1_ready",   64'(in_ready),    64'd1);
      drive(1'b1, 32'h0000_0204, 1'b1, 5'd0, 16'h00B2);
      tick();
      check("bp2_payload", 64'(out_payload), 64'h00A1);
      check("bp2_ready",   64'(in_ready),    64'd0);
      drive(1'b1, 32'h0000_0208, 1'b0, 5'd0, 16'h00C3);
      tick();
      check("bp3_payload", 64'(out_payload), 64'h00A1);
      check("bp3_ready",   64'(in_ready),    64'd0);
      tick();
      check("bp4_payload", 64'(out_payload), 64'h00A1);
      check("bp4_valid",   64'(out_valid),   64'd1);
      check("bp4_ready",   64'(in_ready),    64'd0);
      out_ready = 1'b1;
      tick();
      check("bp5_payload", 64'(out_payload), 64'h00B2);
      check("bp5_pc",      64'(out_pc),      64'h0204);
      check("bp5_bd",      64'(out_bd),      64'd1);
      check("bp5_ready",   64'(in_ready),    64'd1);
      tick();
      check("bp6_payload", 64'(out_payload), 64'h00C3);
      check("bp6_valid",   64'(out_valid),   64'd1);
      drive(1'b0, 32'h0, 1'b0, 5'd0, 16'h0);
      tick();
      check("bp7_valid",   64'(out_valid),   64'd0);

      // flush with both slots full and D offered
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0300, 1'b0, 5'd1, 16'h00E1);
      tick();
      drive(1'b1, 32'h0000_0304, 1'b1, 5'd2, 16'h00F2);
      tick();
      check("fl_pre_ready", 64'(in_ready), 64'd0);
      flush = 1'b1;
      drive(1'b1, 32'h0000_0308, 1'b1, 5'd4, 16'h00D4);
      tick();
      check_reset_outputs("fl");
      check("fl_ready", 64'(in_ready), 64'd1);
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 5'd0, 16'h0);
      tick();
      check("fl_post_valid", 64'(out_valid), 64'd0);

      // flush with only main full: the accepted word is discarded
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0400, 1'b0, 5'd0, 16'h0041);
      tick();
      flush = 1'b1;
      drive(1'b1, 32'h0000_0404, 1'b0, 5'd0, 16'h00D5);
      tick();
      check("fl2_valid", 64'(out_valid), 64'd0);
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 5'd0, 16'h0);
      tick();
      check("fl2_post_valid",   64'(out_valid),   64'd0);
      check("fl2_post_payload", 64'(out_payload), 64'd0);

      // asynchronous reset between edges with the stage full
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0500, 1'b1, 5'd6, 16'h0051);
      tick();
      drive(1'b1, 32'h0000_0504, 1'b0, 5'd8, 16'h0052);
      tick();
      check("ar_pre_valid", 64'(out_valid), 64'd1);
      check("ar_pre_ready", 64'(in_ready),  64'd0);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("ar");
      check("ar_ready", 64'(in_ready), 64'd1);
      drive(1'b0, 32'h0, 1'b0, 5'd0, 16'h0);
      out_ready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("ar_post_valid", 64'(out_valid), 64'd0);
      check("ar_post_ready", 64'(in_ready),  64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
